// File: rtl/axi_stream_sink_pkg.sv
// Shared constants for the AXI4-Stream sink checker:
// register map, STATUS/CONTROL bit positions and the frame FSM states.
package axi_stream_sink_pkg;

   localparam logic [31:0] REG_CONTROL     = 32'h00;
   localparam logic [31:0] REG_STATUS      = 32'h04;
   localparam logic [31:0] REG_BEAT_COUNT  = 32'h08;
   localparam logic [31:0] REG_FRAME_COUNT = 32'h0C;
   localparam logic [31:0] REG_NUM_BYTES   = 32'h10;
   localparam logic [31:0] REG_LAST_ROUTE  = 32'h14;
   localparam logic [31:0] REG_ERR_COUNT   = 32'h18;

   localparam int CTRL_ENABLE = 0;
   localparam int CTRL_CLEAR  = 1;

   localparam int STAT_IN_FRAME   = 0;
   localparam int STAT_FRAME_DONE = 1;
   localparam int STAT_DATA_ERR   = 2;
   localparam int STAT_LEN_ERR    = 3;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FIRST = 2'd1,
      IN_FRAME   = 2'd2
   } fsm_state_e;

endpackage

// File: rtl/axi_stream_sink_checker_frame.sv
// Frame FSM, beat indexing, data/length checks and result counters
// for the stream sink checker.
module stream_frame_checker
   import axi_stream_sink_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ID_W   = 2
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic [DATA_W-1:0] tdata,
   input  logic              tlast,
   input  logic [ID_W-1:0]   tid,
   input  logic [1:0]        tdest,
   input  logic              tvalid,
   output logic              tready,
   input  logic              enable,
   input  logic              clear,
   input  logic [31:0]       expected_beats,
   output logic              in_frame,
   output logic              frame_done,
   output logic              data_err,
   output logic              len_err,
   output logic [31:0]       beat_count,
   output logic [31:0]       frame_count,
   output logic [31:0]       err_count,
   output logic [ID_W-1:0]   route_id,
   output logic [1:0]        route_dest
);

   fsm_state_e  state;
   logic        frame_err;
   logic        accept;
   logic        first;
   logic [31:0] idx;
   logic [31:0] idx_next;
   logic        beat_data_err;
   logic        beat_len_err;
   logic        frame_err_next;

   // beat_count holds the previous beat's idx+1, i.e. the next index
   always_comb begin
      accept         = tvalid && tready;
      first          = (state != IN_FRAME);
      idx            = first ? 32'd0 : beat_count;
      idx_next       = idx + 32'd1;
      beat_data_err  = (tdata != DATA_W'(idx));
      beat_len_err   = tlast ? (idx_next != expected_beats)
                             : (idx_next == expected_beats);
      frame_err_next = (!first && frame_err) || beat_data_err || beat_len_err;
   end

   assign in_frame = (state == IN_FRAME);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         tready      <= 1'b0;
         frame_err   <= 1'b0;
         frame_done  <= 1'b0;
         data_err    <= 1'b0;
         len_err     <= 1'b0;
         beat_count  <= '0;
         frame_count <= '0;
         err_count   <= '0;
         route_id    <= '0;
         route_dest  <= '0;
      end else begin
         tready <= enable;
         if (clear) begin
            state       <= enable ? WAIT_FIRST : IDLE;
            frame_err   <= 1'b0;
            frame_done  <= 1'b0;
            data_err    <= 1'b0;
            len_err     <= 1'b0;
            beat_count  <= '0;
            frame_count <= '0;
            err_count   <= '0;
         end else if (accept) begin
            beat_count <= idx_next;
            frame_err  <= frame_err_next;
            if (beat_data_err) data_err <= 1'b1;
            if (beat_len_err)  len_err  <= 1'b1;
            if (first) begin
               route_id   <= tid;
               route_dest <= tdest;
            end
            if (tlast) begin
               state       <= enable ? WAIT_FIRST : IDLE;
               frame_done  <= 1'b1;
               frame_count <= frame_count + 32'd1;
               if (frame_err_next && (err_count != '1))
                  err_count <= err_count + 32'd1;
            end else begin
               state <= IN_FRAME;
            end
         end else begin
            case (state)
               IDLE:       if (enable)  state <= WAIT_FIRST;
               WAIT_FIRST: if (!enable) state <= IDLE;
               IN_FRAME:   ;
               default:    state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/axi_stream_sink_checker.sv
// AXI4-Stream sink checker top: AXI4-Lite register file around
// the frame checker.
module axi_stream_sink_checker
   import axi_stream_sink_pkg::*;
#(
   parameter int STREAM_DATA_WIDTH  = 32,
   parameter int STREAM_ID_WIDTH    = 2,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                            clock,
   input  logic                            resetn,
   input  logic [STREAM_DATA_WIDTH-1:0]    TDATA,
   input  logic                            TLAST,
   input  logic [STREAM_ID_WIDTH-1:0]      TID,
   input  logic [1:0]                      TDEST,
   input  logic                            TVALID,
   output logic                            TREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam logic [DW-1:0] BPB = DW'(STREAM_DATA_WIDTH / 8);

   logic                          wready_pending;
   logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q;
   logic                          bvalid;
   logic                          rvalid;
   logic [DW-1:0]                 rdata;
   logic [DW-1:0]                 rmux;
   logic                          enable;
   logic [DW-1:0]                 num_bytes;
   logic                          aw_fire;
   logic                          w_fire;
   logic                          ar_fire;
   logic [31:0]                   wa;
   logic [31:0]                   ra;
   logic                          clear;
   logic [31:0]                   expected_beats;
   logic                          in_frame;
   logic                          frame_done;
   logic                          data_err;
   logic                          len_err;
   logic [31:0]                   beat_count;
   logic [31:0]                   frame_count;
   logic [31:0]                   err_count;
   logic [STREAM_ID_WIDTH-1:0]    route_id;
   logic [1:0]                    route_dest;
   logic                          unused;

   assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB};

   assign S_AXI_AWREADY = !wready_pending;
   assign S_AXI_WREADY  = wready_pending;
   assign S_AXI_BVALID  = bvalid;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_ARREADY = !rvalid;
   assign S_AXI_RVALID  = rvalid;
   assign S_AXI_RDATA   = rdata;
   assign S_AXI_RRESP   = 2'b00;

   assign aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_fire  = S_AXI_WVALID && S_AXI_WREADY;
   assign ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;
   assign wa      = 32'(awaddr_q);
   assign ra      = 32'(S_AXI_ARADDR);

   // CLEAR acts on the write cycle itself so it beats a coincident beat
   assign clear = w_fire && (wa == REG_CONTROL) && S_AXI_WDATA[CTRL_CLEAR];
   assign expected_beats = 32'(num_bytes / BPB);

   always_comb begin
      rmux = '0;
      case (ra)
         REG_CONTROL: rmux[CTRL_ENABLE] = enable;
         REG_STATUS: begin
            rmux[STAT_IN_FRAME]   = in_frame;
            rmux[STAT_FRAME_DONE] = frame_done;
            rmux[STAT_DATA_ERR]   = data_err;
            rmux[STAT_LEN_ERR]    = len_err;
         end
         REG_BEAT_COUNT:  rmux = DW'(beat_count);
         REG_FRAME_COUNT: rmux = DW'(frame_count);
         REG_NUM_BYTES:   rmux = num_bytes;
         REG_LAST_ROUTE: begin
            rmux[1:0]                 = route_dest;
            rmux[STREAM_ID_WIDTH+7:8] = route_id;
         end
         REG_ERR_COUNT:   rmux = DW'(err_count);
         default:         ;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wready_pending <= 1'b0;
         awaddr_q       <= '0;
         bvalid         <= 1'b0;
         rvalid         <= 1'b0;
         rdata          <= '0;
         enable         <= 1'b0;
         num_bytes      <= '0;
      end else begin
         if (aw_fire) begin
            awaddr_q       <= S_AXI_AWADDR;
            wready_pending <= 1'b1;
         end
         if (w_fire) begin
            wready_pending <= 1'b0;
            bvalid         <= 1'b1;
            if (wa == REG_CONTROL)   enable    <= S_AXI_WDATA[CTRL_ENABLE];
            if (wa == REG_NUM_BYTES) num_bytes <= S_AXI_WDATA;
         end else if (bvalid && S_AXI_BREADY) begin
            bvalid <= 1'b0;
         end
         if (ar_fire) begin
            rdata  <= rmux;
            rvalid <= 1'b1;
         end else if (rvalid && S_AXI_RREADY) begin
            rvalid <= 1'b0;
         end
      end
   end

   stream_frame_checker #(
      .DATA_W (STREAM_DATA_WIDTH),
      .ID_W   (STREAM_ID_WIDTH)
   ) u_frame (
      .clock          (clock),
      .resetn         (resetn),
      .tdata          (TDATA),
      .tlast          (TLAST),
      .tid            (TID),
      .tdest          (TDEST),
      .tvalid         (TVALID),
      .tready         (TREADY),
      .enable         (enable),
      .clear          (clear),
      .expected_beats (expected_beats),
      .in_frame       (in_frame),
      .frame_done     (frame_done),
      .data_err       (data_err),
      .len_err        (len_err),
      .beat_count     (beat_count),
      .frame_count    (frame_count),
      .err_count      (err_count),
      .route_id       (route_id),
      .route_dest     (route_dest)
   );

endmodule

// File: tb/tb_axi_stream_sink_checker.sv
// Directed self-checking bench for axi_stream_sink_checker:
// register access, frame checks, disable/clear/reset corner cases.
module tb_axi_stream_sink_checker;

   localparam int LIMIT = 50;

   logic        clock;
   logic        resetn;
   logic [31:0] TDATA;
   logic        TLAST;
   logic [1:0]  TID;
   logic [1:0]  TDEST;
   logic        TVALID;
   logic        TREADY;
   logic [4:0]  AWADDR;
   logic [2:0]  AWPROT;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic [4:0]  ARADDR;
   logic [2:0]  ARPROT;
   logic        ARVALID;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY;

   int n_tests = 0;
   int n_fail  = 0;

   axi_stream_sink_checker dut (
      .clock         (clock),
      .resetn        (resetn),
      .TDATA         (TDATA),
      .TLAST         (TLAST),
      .TID           (TID),
      .TDEST         (TDEST),
      .TVALID        (TVALID),
      .TREADY        (TREADY),
      .S_AXI_AWADDR  (AWADDR),
      .S_AXI_AWPROT  (AWPROT),
      .S_AXI_AWVALID (AWVALID),
      .S_AXI_AWREADY (AWREADY),
      .S_AXI_WDATA   (WDATA),
      .S_AXI_WSTRB   (WSTRB),
      .S_AXI_WVALID  (WVALID),
      .S_AXI_WREADY  (WREADY),
      .S_AXI_BRESP   (BRESP),
      .S_AXI_BVALID  (BVALID),
      .S_AXI_BREADY  (BREADY),
      .S_AXI_ARADDR  (ARADDR),
      .S_AXI_ARPROT  (ARPROT),
      .S_AXI_ARVALID (ARVALID),
      .S_AXI_ARREADY (ARREADY),
      .S_AXI_RDATA   (RDATA),
      .S_AXI_RRESP   (RRESP),
      .S_AXI_RVALID  (RVALID),
      .S_AXI_RREADY  (RREADY)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic aw_phase(input logic [4:0] addr);
      int n = 0;
      AWADDR  = addr;
      AWVALID = 1'b1;
      while (!AWREADY && n < LIMIT) begin step(1); n++; end
      if (n >= LIMIT) check("awready_wait", 32'(AWREADY), 32'd1);
      step(1);
      AWVALID = 1'b0;
   endtask

   task automatic b_phase();
      int n = 0;
      BREADY = 1'b1;
      while (!BVALID && n < LIMIT) begin step(1); n++; end
      if (n >= LIMIT) check("bvalid_wait", 32'(BVALID), 32'd1);
      step(1);
      BREADY = 1'b0;
   endtask

   task automatic axi_write(input logic [4:0] addr, input logic [31:0] data);
      int n = 0;
      aw_phase(addr);
      WDATA  = data;
      WVALID = 1'b1;
      while (!WREADY && n < LIMIT) begin step(1); n++; end
      if (n >= LIMIT) check("wready_wait", 32'(WREADY), 32'd1);
      step(1);
      WVALID = 1'b0;
      b_phase();
   endtask

   task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
      int n = 0;
      ARADDR  = addr;
      ARVALID = 1'b1;
      while (!ARREADY && n < LIMIT) begin step(1); n++; end
      if (n >= LIMIT) check("arready_wait", 32'(ARREADY), 32'd1);
      step(1);
      ARVALID = 1'b0;
      RREADY  = 1'b1;
      n = 0;
      while (!RVALID && n < LIMIT) begin step(1); n++; end
      if (n >= LIMIT) check("rvalid_wait", 32'(RVALID), 32'd1);
      data = RDATA;
      step(1);
      RREADY = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [4:0] addr,
                           input logic [31:0] exp);
      logic [31:0] d;
      axi_read(addr, d);
      check(tag, d, exp);
   endtask

   task automatic send_beat(input logic [31:0] d, input logic last,
                            input logic [1:0] id, input logic [1:0] dest);
      int n = 0;
      TDATA  = d;
      TLAST  = last;
      TID    = id;
      TDEST  = dest;
      TVALID = 1'b1;
      while (!TREADY && n < LIMIT) begin step(1); n++; end
      if (n >= LIMIT) check("tready_wait", 32'(TREADY), 32'd1);
      step(1);
      TVALID = 1'b0;
      TLAST  = 1'b0;
   endtask

   // beats carry their index, except beat `bad` which carries 5
   task automatic send_frame(input int nbeats, input int bad,
                             input logic [1:0] id, input logic [1:0] dest);
      for (int i = 0; i < nbeats; i++)
         send_beat((i == bad) ? 32'd5 : 32'(i), (i == nbeats - 1), id, dest);
   endtask

   initial begin
      resetn  = 1'b0;
      TDATA   = '0;
      TLAST   = 1'b0;
      TID     = '0;
      TDEST   = '0;
      TVALID  = 1'b0;
      AWADDR  = '0;
      AWPROT  = '0;
      AWVALID = 1'b0;
      WDATA   = '0;
      WSTRB   = 4'hF;
      WVALID  = 1'b0;
      BREADY  = 1'b0;
      ARADDR  = '0;
      ARPROT  = '0;
      ARVALID = 1'b0;
      RREADY  = 1'b0;
      step(3);
      resetn = 1'b1;
      step(1);

      // reset state
      check("rst_tready", 32'(TREADY), 32'd0);
      check("rst_awready", 32'(AWREADY), 32'd1);
      check("rst_arready", 32'(ARREADY), 32'd1);
      check("rst_wready", 32'(WREADY), 32'd0);
      check("rst_bvalid", 32'(BVALID), 32'd0);
      check("rst_rvalid", 32'(RVALID), 32'd0);
      check("rst_bresp", 32'(BRESP), 32'd0);
      rd_check("rst_status", 5'h04, 32'h0);
      check("rst_rresp", 32'(RRESP), 32'd0);

      // clean 4-beat frame, TDEST=2
      axi_write(5'h10, 32'd16);
      axi_write(5'h00, 32'd1);
      rd_check("ctrl_rb", 5'h00, 32'h1);
      rd_check("nbytes_rb", 5'h10, 32'd16);
      send_frame(4, -1, 2'd0, 2'd2);
      rd_check("ok_status", 5'h04, 32'h2);
      rd_check("ok_frames", 5'h0C, 32'd1);
      rd_check("ok_beats", 5'h08, 32'd4);
      rd_check("ok_errs", 5'h18, 32'd0);
      rd_check("ok_route", 5'h14, 32'h2);

      // data error 0,1,5,3
      axi_write(5'h00, 32'h3);
      rd_check("clr_status", 5'h04, 32'h0);
      rd_check("clr_frames", 5'h0C, 32'd0);
      rd_check("clr_ctrl_rb", 5'h00, 32'h1);
      send_frame(4, 2, 2'd1, 2'd1);
      rd_check("derr_status", 5'h04, 32'h6);
      rd_check("derr_errs", 5'h18, 32'd1);
      rd_check("derr_route", 5'h14, 32'h101);

      // short frame then long frame
      axi_write(5'h00, 32'h3);
      send_frame(2, -1, 2'd0, 2'd0);
      rd_check("short_status", 5'h04, 32'hA);
      rd_check("short_beats", 5'h08, 32'd2);
      send_frame(6, -1, 2'd0, 2'd0);
      rd_check("long_beats", 5'h08, 32'd6);
      rd_check("long_errs", 5'h18, 32'd2);
      rd_check("long_frames", 5'h0C, 32'd2);

      // length truncation: 3 bytes -> 0 beats, 7 bytes -> 1 beat
      axi_write(5'h00, 32'h3);
      axi_write(5'h10, 32'd3);
      send_frame(1, -1, 2'd0, 2'd0);
      rd_check("zero_status", 5'h04, 32'hA);
      rd_check("zero_errs", 5'h18, 32'd1);
      axi_write(5'h10, 32'd7);
      send_frame(1, -1, 2'd0, 2'd0);
      rd_check("one_errs", 5'h18, 32'd1);
      rd_check("one_frames", 5'h0C, 32'd2);
      rd_check("one_beats", 5'h08, 32'd1);
      axi_write(5'h1C, 32'hFFFF);
      rd_check("unmapped", 5'h1C, 32'h0);
      rd_check("nbytes_keep", 5'h10, 32'd7);

      // disable mid-frame, then resume
      axi_write(5'h10, 32'd16);
      axi_write(5'h00, 32'h3);
      send_beat(32'd0, 1'b0, 2'd0, 2'd0);
      send_beat(32'd1, 1'b0, 2'd0, 2'd0);
      axi_write(5'h00, 32'h0);
      step(1);
      check("dis_tready", 32'(TREADY), 32'd0);
      rd_check("dis_status", 5'h04, 32'h1);
      axi_write(5'h00, 32'h1);
      send_beat(32'd2, 1'b0, 2'd0, 2'd0);
      send_beat(32'd3, 1'b1, 2'd0, 2'd0);
      rd_check("resume_status", 5'h04, 32'h2);
      rd_check("resume_errs", 5'h18, 32'd0);
      rd_check("resume_beats", 5'h08, 32'd4);

      // CLEAR in the same cycle as the TLAST beat
      send_beat(32'd0, 1'b0, 2'd0, 2'd0);
      send_beat(32'd1, 1'b0, 2'd0, 2'd0);
      send_beat(32'd2, 1'b0, 2'd0, 2'd0);
      aw_phase(5'h00);
      WDATA  = 32'h3;
      WVALID = 1'b1;
      TDATA  = 32'd3;
      TLAST  = 1'b1;
      TVALID = 1'b1;
      check("cb_both_ready", {30'd0, WREADY, TREADY}, 32'h3);
      step(1);
      WVALID = 1'b0;
      TVALID = 1'b0;
      TLAST  = 1'b0;
      b_phase();
      rd_check("cb_frames", 5'h0C, 32'd0);
      rd_check("cb_beats", 5'h08, 32'd0);
      rd_check("cb_errs", 5'h18, 32'd0);
      rd_check("cb_status", 5'h04, 32'h0);

      // reset mid-frame
      send_beat(32'd0, 1'b0, 2'd0, 2'd0);
      send_beat(32'd1, 1'b0, 2'd0, 2'd0);
      resetn = 1'b0;
      #1;
      check("arst_tready", 32'(TREADY), 32'd0);
      step(2);
      resetn = 1'b1;
      step(1);
      rd_check("arst_nbytes", 5'h10, 32'd0);
      rd_check("arst_status", 5'h04, 32'h0);
      axi_write(5'h10, 32'd16);
      axi_write(5'h00, 32'h1);
      send_frame(4, -1, 2'd0, 2'd0);
      rd_check("post_status", 5'h04, 32'h2);
      rd_check("post_frames", 5'h0C, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_stream_sink_checker.md
Name: axi_stream_sink_checker

Overview:
AXI4-Stream slave that receives frames from the stream source (incrementing-word pattern, TLAST-delimited) and checks each frame for data and length correctness.
Results are held in counters and sticky flags, readable over an AXI4-Lite slave register port.
Sits at the far end of the stream link for loopback and bring-up testing, under software control.

Parameters:
STREAM_DATA_WIDTH, 32, TDATA width in bits; bytes per beat = STREAM_DATA_WIDTH/8.
STREAM_ID_WIDTH, 2, TID width.
C_S_AXI_DATA_WIDTH, 32, AXI4-Lite data width.
C_S_AXI_ADDR_WIDTH, 5, AXI4-Lite address width.

Ports:
clock  in  1  single system clock; all logic on posedge.
resetn  in  1  asynchronous active-low reset.
TDATA  in  STREAM_DATA_WIDTH  stream data.
TLAST  in  1  last beat of frame.
TID  in  STREAM_ID_WIDTH  stream ID.
TDEST  in  2  stream destination.
TVALID  in  1  beat valid.
TREADY  out  1  sink ready.
S_AXI_AW*/W*/B*/AR*/R*  AXI4-Lite slave, standard directions; AWADDR/ARADDR C_S_AXI_ADDR_WIDTH, WDATA/RDATA C_S_AXI_DATA_WIDTH, WSTRB C_S_AXI_DATA_WIDTH/8, AWPROT/ARPROT 3 (ignored), BRESP/RRESP 2.

Behaviour:
- Reset: one clock; reset is asynchronous, active-low, and applies to all flops. Reset values: TREADY=0, BVALID=0, RVALID=0, RDATA=0, AWREADY=1, WREADY=0, ARREADY=1, all registers and counters 0, FSM=IDLE.
- BRESP and RRESP are always 2'b00.
- AXI4-Lite write:
  - AWREADY = !wready_pending. The AW handshake latches the address and sets wready_pending.
  - WREADY = wready_pending. The W handshake clears wready_pending, sets BVALID the next cycle and performs the write.
  - BVALID holds until BREADY.
  - WSTRB is ignored: full-word writes only.
- AXI4-Lite read:
  - ARREADY = !RVALID.
  - The AR handshake registers RDATA; RVALID rises the next cycle and holds until RREADY.
  - Unmapped addresses read 0; writes to them are accepted and ignored.
- Register map:
  - 0x00 CONTROL (RW): bit0 ENABLE; bit1 CLEAR, write-1 pulse, always reads 0.
  - 0x04 STATUS (RO): bit0 IN_FRAME; bit1 FRAME_DONE (sticky); bit2 DATA_ERR (sticky); bit3 LEN_ERR (sticky).
  - 0x08 BEAT_COUNT (RO): beats accepted in the current or last frame.
  - 0x0C FRAME_COUNT (RO): completed frames.
  - 0x10 NUM_BYTES (RW): expected frame length in bytes. expected_beats = NUM_BYTES/bytes_per_beat, truncating.
  - 0x14 LAST_ROUTE (RO): [1:0] TDEST and [STREAM_ID_WIDTH+7:8] TID, captured on the first beat of each frame.
  - 0x18 ERR_COUNT (RO): frames with DATA_ERR or LEN_ERR. Saturates at all-ones.
- TREADY is registered and equals ENABLE one cycle after the CONTROL write. A beat is accepted when TVALID && TREADY.
- FSM:
  - IDLE: ENABLE=0.
  - WAIT_FIRST: ENABLE=1, no frame open.
  - IN_FRAME: at least one beat of the current frame accepted.
  - Transitions: IDLE→WAIT_FIRST when ENABLE=1. WAIT_FIRST→IN_FRAME on an accepted beat with TLAST=0. WAIT_FIRST→WAIT_FIRST on an accepted beat with TLAST=1 (single-beat frame). IN_FRAME→WAIT_FIRST on an accepted TLAST beat. WAIT_FIRST→IDLE when ENABLE=0.
  - ENABLE=0 in IN_FRAME: stay in IN_FRAME with TREADY=0. The frame resumes on re-enable.
- Per-beat checks:
  - beat_idx is the 0-based index within the frame. The first beat resets it; BEAT_COUNT = beat_idx+1 after each accepted beat.
  - DATA_ERR sets if TDATA != beat_idx, with beat_idx zero-extended or truncated to STREAM_DATA_WIDTH.
  - LEN_ERR sets on a TLAST beat when beat_idx+1 != expected_beats.
  - LEN_ERR also sets on a non-TLAST beat when beat_idx+1 == expected_beats (TLAST missing). Receiving continues until TLAST; beat_idx is 32 bits and wraps.
  - expected_beats=0: any frame sets LEN_ERR.
- On an accepted TLAST beat: FRAME_COUNT+1 (wraps), FRAME_DONE=1. ERR_COUNT+1 if this frame set any error, including on this beat.
- CLEAR zeroes BEAT_COUNT, FRAME_COUNT, ERR_COUNT and the sticky bits, and returns the FSM to WAIT_FIRST or IDLE. CLEAR wins over a same-cycle beat: that beat is still accepted but discarded.
- Reset mid-frame: all state is lost, and the next beat is treated as the first beat of a new frame.

Decomposition:
- Package axi_stream_sink_pkg: register address localparams (0x00–0x18), STATUS bit indices, and the FSM enum {IDLE, WAIT_FIRST, IN_FRAME}.
- One sub-module, stream_frame_checker: FSM, beat_idx, error detection and counters. Inputs are the stream signals, enable, clear and expected_beats; outputs are the status and counters.
- The top level holds the AXI4-Lite register file.

Test Plan:
- Reset, read 0x04 → 0; TREADY=0; AWREADY=1, ARREADY=1.
- Write NUM_BYTES=16, CONTROL=1; send 4 beats with TDATA 0,1,2,3 and TLAST on beat 3, TDEST=2 → STATUS=0x2, FRAME_COUNT=1, BEAT_COUNT=4, ERR_COUNT=0, LAST_ROUTE=0x2.
- NUM_BYTES=16; send TDATA 0,1,5,3 → STATUS=0x6, ERR_COUNT=1.
- NUM_BYTES=16; TLAST on beat 1 → LEN_ERR; TLAST on beat 5 → LEN_ERR, BEAT_COUNT=6.
- Write CONTROL=0 mid-frame after 2 beats → TREADY=0 next cycle, STATUS bit0=1; re-enable, send the remaining 2 beats → no error.
- Write CONTROL=0x3 on the same cycle as a TLAST beat → all counters 0, STATUS=0; assert resetn low mid-frame → TREADY=0 immediately.
